// File: rtl/shifter_pkg.sv
// Shared types for the pipelined shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shifter_pipe_if.sv
// Handshake bus of shifter_pipe. Status flags exist only when SHIFTER_STATUS_EN is defined.
interface shifter_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [SHAMT_W-1:0] in_shamt;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
`ifdef SHIFTER_STATUS_EN
  logic               out_zero;
  logic               out_carry;
`endif

  modport master (
    output in_valid, in_op, in_shamt, in_data, out_ready,
    input  in_ready, out_valid, out_data
`ifdef SHIFTER_STATUS_EN
    , input out_zero, out_carry
`endif
  );

  modport slave (
    input  in_valid, in_op, in_shamt, in_data, out_ready,
    output in_ready, out_valid, out_data
`ifdef SHIFTER_STATUS_EN
    , output out_zero, out_carry
`endif
  );

endinterface

// File: rtl/shifter_stage.sv
// One combinational shifter stage: conditional shift by 2**STAGE in the requested mode.
// Carry tracking ports exist only when SHIFTER_STATUS_EN is defined.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGE = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_t        op_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
`ifdef SHIFTER_STATUS_EN
  ,
  input  logic             carry_i,
  output logic             carry_o
`endif
);

  localparam int unsigned N = 1 << STAGE;

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      unique case (op_i)
        OP_LSL: data_o = data_i << N;
        OP_LSR: data_o = data_i >> N;
        // Partially shifted ASR data keeps the original sign in its MSB.
        OP_ASR: data_o = $signed(data_i) >>> N;
        OP_ROR: data_o = (data_i >> N) | (data_i << (WIDTH - N));
      endcase
    end
  end

`ifdef SHIFTER_STATUS_EN
  // Last bit leaving this stage; for ROR it is also the new MSB.
  always_comb begin
    carry_o = carry_i;
    if (en_i) begin
      if (op_i == OP_LSL) carry_o = data_i[WIDTH-N];
      else                carry_o = data_i[N-1];
    end
  end
`endif

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined LSL/LSR/ASR/ROR shifter, one register stage per shift-amount bit, valid/ready on
// both sides. Define SHIFTER_STATUS_EN to add the out_zero/out_carry flags.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           reset_n,
  shifter_pipe_if.slave bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic advance;

  // The whole pipeline moves as one; it only freezes on an unaccepted result.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic [WIDTH-1:0]   d_in;
    logic [WIDTH-1:0]   d_out;
    shift_op_t          op_in;
    logic [SHAMT_W-1:k] sh_in;
    logic               v_in;
    logic [WIDTH-1:0]   data_q;
    logic               valid_q;
`ifdef SHIFTER_STATUS_EN
    logic               c_in;
    logic               c_out;
    logic               carry_q;
`endif

    if (k == 0) begin : g_first
      assign d_in  = bus.in_data;
      assign op_in = shift_op_t'(bus.in_op);
      assign sh_in = bus.in_shamt;
      assign v_in  = bus.in_valid;
`ifdef SHIFTER_STATUS_EN
      assign c_in  = 1'b0;
`endif
    end else begin : g_next
      assign d_in  = g_stage[k-1].data_q;
      assign op_in = g_stage[k-1].g_fwd.op_q;
      assign sh_in = g_stage[k-1].g_fwd.shamt_q;
      assign v_in  = g_stage[k-1].valid_q;
`ifdef SHIFTER_STATUS_EN
      assign c_in  = g_stage[k-1].carry_q;
`endif
    end

    shifter_stage #(
      .WIDTH (WIDTH),
      .STAGE (k)
    ) u_stage (
      .data_i  (d_in),
      .op_i    (op_in),
      .en_i    (sh_in[k]),
      .data_o  (d_out)
`ifdef SHIFTER_STATUS_EN
      ,
      .carry_i (c_in),
      .carry_o (c_out)
`endif
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (advance) begin
        data_q  <= d_out;
        valid_q <= v_in;
      end
    end

`ifdef SHIFTER_STATUS_EN
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     carry_q <= 1'b0;
      else if (advance) carry_q <= c_out;
    end
`endif

    // Only the shift-amount bits still to be applied travel forward.
    if (k < SHAMT_W - 1) begin : g_fwd
      shift_op_t            op_q;
      logic [SHAMT_W-1:k+1] shamt_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          op_q    <= OP_LSL;
          shamt_q <= '0;
        end else if (advance) begin
          op_q    <= op_in;
          shamt_q <= sh_in[SHAMT_W-1:k+1];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[SHAMT_W-1].valid_q;
  assign bus.out_data  = g_stage[SHAMT_W-1].data_q;

`ifdef SHIFTER_STATUS_EN
  logic zero_q;

  // Registered so the flag reads 0 out of reset even though out_data is 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     zero_q <= 1'b0;
    else if (advance) zero_q <= (g_stage[SHAMT_W-1].d_out == '0);
  end

  assign bus.out_zero  = zero_q;
  assign bus.out_carry = g_stage[SHAMT_W-1].carry_q;
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// Randomised and directed bench for shifter_pipe (WIDTH = 8) against a behavioural model.
module tb_shifter_pipe;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 3;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       carry;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [2:0] sh;
    logic [7:0] d;
  } op_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  shifter_pipe_if #(.WIDTH(W)) bus ();

  shifter_pipe #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_accepted = 0;
  int   n_delivered = 0;
  bit   lat_en = 1'b0;
  bit   acc_flag;
  exp_t exp_q[$];
  op_t  pend[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] ref_data(input logic [1:0] op, input logic [7:0] d, input int s);
    int unsigned x;
    int unsigned r;
    x = d;
    case (op)
      2'd0:    r = x << s;
      2'd1:    r = x >> s;
      2'd2:    r = d[7] ? ((x >> s) | (32'hFF << (8 - s))) : (x >> s);
      default: r = (x >> s) | (x << (8 - s));
    endcase
    return r[7:0];
  endfunction

  function automatic logic ref_carry(input logic [1:0] op, input logic [7:0] d, input int s);
    logic [7:0] res;
    res = ref_data(op, d, s);
    if (s == 0)        return 1'b0;
    else if (op == 0)  return d[8-s];
    else if (op == 3)  return res[7];
    else               return d[s-1];
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input logic [2:0] sh,
                      input logic [7:0] d, input logic ordy);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_shamt  = sh;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    cyc++;
    acc_flag = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data", {24'd0, bus.out_data}, {24'd0, e.data});
        if (lat_en) check("latency", cyc - e.cyc, LAT);
`ifdef SHIFTER_STATUS_EN
        check("zero", {31'd0, bus.out_zero}, {31'd0, e.zero});
        check("carry", {31'd0, bus.out_carry}, {31'd0, e.carry});
`endif
        n_delivered++;
      end
    end
    if (v && bus.in_ready) begin
      e.data  = ref_data(op, d, int'(sh));
      e.zero  = (e.data == 8'h00);
      e.carry = ref_carry(op, d, int'(sh));
      e.cyc   = cyc;
      exp_q.push_back(e);
      n_accepted++;
      acc_flag = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 2'd0, 3'd0, 8'h00, 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 2'd0, 3'd0, 8'h00, 1'b1);
      check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] held;
    bit         held_v;
    int         acc0;
    int         del0;
    op_t        mode_tab[5];

    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_shamt  = 3'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef SHIFTER_STATUS_EN
    check("rst_zero", {31'd0, bus.out_zero}, 32'd0);
    check("rst_carry", {31'd0, bus.out_carry}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    idle_check(10);

    // Back-to-back LSR of 0x3D by 0..3, then the mode table, with fixed latency
    lat_en = 1'b1;
    for (int s = 0; s < 4; s++) step(1'b1, 2'd1, 3'(s), 8'h3D, 1'b1);
    drain();
    mode_tab[0] = '{op: 2'd2, sh: 3'd2, d: 8'h9C};
    mode_tab[1] = '{op: 2'd3, sh: 3'd3, d: 8'h9C};
    mode_tab[2] = '{op: 2'd0, sh: 3'd2, d: 8'h3D};
    mode_tab[3] = '{op: 2'd1, sh: 3'd7, d: 8'h9C};
    mode_tab[4] = '{op: 2'd2, sh: 3'd7, d: 8'h7F};
    for (int i = 0; i < 5; i++) step(1'b1, mode_tab[i].op, mode_tab[i].sh, mode_tab[i].d, 1'b1);
    drain();
    check("mode_asr_spot", {24'd0, ref_data(2'd2, 8'h9C, 2)}, 32'hE7);
    // Status-oriented operations
    step(1'b1, 2'd1, 3'd1, 8'h01, 1'b1);
    step(1'b1, 2'd0, 3'd2, 8'h3D, 1'b1);
    step(1'b1, 2'd1, 3'd3, 8'h3D, 1'b1);
    step(1'b1, 2'd3, 3'd0, 8'hA5, 1'b1);
    drain();
    lat_en = 1'b0;

    // Backpressure: five ops offered against a stalled consumer
    pend = '{'{2'd0, 3'd1, 8'h11}, '{2'd1, 3'd2, 8'h82}, '{2'd2, 3'd3, 8'hC4},
             '{2'd3, 3'd4, 8'h5A}, '{2'd1, 3'd5, 8'hF0}};
    acc0   = n_accepted;
    del0   = n_delivered;
    held_v = 1'b0;
    held   = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pend[0].op, pend[0].sh, pend[0].d, 1'b0);
      if (acc_flag) void'(pend.pop_front());
      if (bus.out_valid) begin
        if (!held_v) begin
          held   = bus.out_data;
          held_v = 1'b1;
        end
        check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("stall_data", {24'd0, bus.out_data}, {24'd0, held});
      end
    end
    check("bp_accepted", n_accepted - acc0, 3);
    for (int i = 0; i < 20 && pend.size() > 0; i++) begin
      step(1'b1, pend[0].op, pend[0].sh, pend[0].d, 1'b1);
      if (acc_flag) void'(pend.pop_front());
    end
    drain();
    check("bp_delivered", n_delivered - del0, 5);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(1'(($urandom % 4) != 0), 2'($urandom % 4), 3'($urandom % 8), 8'($urandom),
           1'(($urandom % 3) != 0));
    end
    drain();
    check("total_delivered", n_delivered, n_accepted);

    // Reset with operations in flight behind a stalled output
    for (int i = 0; i < 6 && !bus.out_valid; i++) step(1'b1, 2'd1, 3'd1, 8'h42, 1'b0);
    check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid", {31'd0, bus.out_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    idle_check(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
